cr16_uart_loader: RTL

- Boot-stage block directly upstream of the CR16 top-level.
- Receives a program image over a UART serial line and writes it word-by-word into BRAM port A.
- Holds the CR16 core in reset until the whole image is written, then releases it.
- Replaces static BRAM init files for on-board program loading; shares BRAM port A with the core through an external mux selected by O_LOAD_DONE.

---
 rtl/cr16_uart_loader.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/cr16_uart_loader.sv
// UART boot loader: receives an 8N1 program image (16-bit header N, then N words,
// each high byte first), writes it into BRAM port A, then releases the CR16 core.
module cr16_uart_loader #(
    parameter int unsigned P_CLK_FREQ_HZ   = 50000000,
    parameter int unsigned P_BAUD_RATE     = 115200,
    parameter int unsigned P_ADDRESS_WIDTH = 16,
    parameter int unsigned P_START_ADDRESS = 0,
    parameter int unsigned P_MAX_WORDS     = 1024
) (
    input  logic                       I_CLK,
    input  logic                       I_NRESET,
    input  logic                       I_UART_RX,
    output logic [15:0]                O_MEM_DATA,
    output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS,
    output logic                       O_MEM_WRITE_ENABLE,
    output logic                       O_CR16_NRESET,
    output logic                       O_LOAD_DONE,
    output logic                       O_LOAD_ERROR,
    output logic [15:0]                O_WORD_COUNT
);

    localparam int unsigned AW           = P_ADDRESS_WIDTH;
    localparam int unsigned CLKS_PER_BIT = P_CLK_FREQ_HZ / P_BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((HALF_BIT > 0) ? HALF_BIT - 1 : 0);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        LD_HDR_HI,
        LD_HDR_LO,
        LD_DATA_HI,
        LD_DATA_LO,
        LD_WRITE,
        LD_DONE,
        LD_ERROR
    } ld_state_t;

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    rx_state_t        rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;

    logic             stop_sample_c;
    logic             byte_valid_c;
    logic             frame_error_c;

    ld_state_t        ld_state;
    logic [7:0]       hdr_hi;
    logic [15:0]      word_total;
    logic [7:0]       data_hi;
    logic [AW-1:0]    addr;
    logic [15:0]      header_c;

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= I_UART_RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // 8N1 receiver: mid-bit sampling referenced to the detected start edge
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Stop-bit sample decides between a delivered byte and a frame error
    always_comb begin
        stop_sample_c = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST);
        byte_valid_c  = stop_sample_c && rx_sync;
        frame_error_c = stop_sample_c && !rx_sync;
        header_c      = {hdr_hi, rx_shift};
    end

    // Loader: header parse, word assembly, BRAM write and core reset release
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            ld_state           <= LD_HDR_HI;
            hdr_hi             <= '0;
            word_total         <= '0;
            data_hi            <= '0;
            addr               <= AW'(P_START_ADDRESS);
            O_MEM_DATA         <= '0;
            O_MEM_ADDRESS      <= '0;
            O_MEM_WRITE_ENABLE <= 1'b0;
            O_CR16_NRESET      <= 1'b0;
            O_LOAD_DONE        <= 1'b0;
            O_LOAD_ERROR       <= 1'b0;
            O_WORD_COUNT       <= '0;
        end else begin
            O_MEM_WRITE_ENABLE <= 1'b0;
            if (frame_error_c && (ld_state != LD_DONE) && (ld_state != LD_ERROR)) begin
                ld_state     <= LD_ERROR;
                O_LOAD_ERROR <= 1'b1;
            end else begin
                case (ld_state)
                    LD_HDR_HI: begin
                        if (byte_valid_c) begin
                            hdr_hi   <= rx_shift;
                            ld_state <= LD_HDR_LO;
                        end
                    end
                    LD_HDR_LO: begin
                        if (byte_valid_c) begin
                            word_total <= header_c;
                            if (header_c == 16'd0) begin
                                ld_state      <= LD_DONE;
                                O_LOAD_DONE   <= 1'b1;
                                O_CR16_NRESET <= 1'b1;
                            end else if (32'(header_c) > P_MAX_WORDS) begin
                                ld_state     <= LD_ERROR;
                                O_LOAD_ERROR <= 1'b1;
                            end else begin
                                ld_state <= LD_DATA_HI;
                            end
                        end
                    end
                    LD_DATA_HI: begin
                        if (byte_valid_c) begin
                            data_hi  <= rx_shift;
                            ld_state <= LD_DATA_LO;
                        end
                    end
                    LD_DATA_LO: begin
                        if (byte_valid_c) begin
                            O_MEM_WRITE_ENABLE <= 1'b1;
                            O_MEM_DATA         <= {data_hi, rx_shift};
                            O_MEM_ADDRESS      <= addr;
                            ld_state           <= LD_WRITE;
                        end
                    end
                    LD_WRITE: begin
                        addr         <= addr + AW'(1);
                        O_WORD_COUNT <= O_WORD_COUNT + 16'd1;
                        if ((O_WORD_COUNT + 16'd1) == word_total) begin
                            ld_state      <= LD_DONE;
                            O_LOAD_DONE   <= 1'b1;
                            O_CR16_NRESET <= 1'b1;
                        end else begin
                            ld_state <= LD_DATA_HI;
                        end
                    end
                    LD_DONE:  ld_state <= LD_DONE;
                    LD_ERROR: ld_state <= LD_ERROR;
                    default:  ld_state <= LD_ERROR;
                endcase
            end
        end
    end

endmodule
